stc0_bf_seq: RTL and testbench

Configuration sequencer for the stc0 FFT butterfly chain. On a host Start it loads each stage's twiddle SRAM through the chained data path and then writes each stage's run-mode control word with the per-stage scaling schedule. It sits between the host register interface and butterfly stage 0, and drives the chain's control bus and ingress data lanes. The chain must not carry FFT traffic while this block is Busy.

---
 rtl/stc0_bf_seq_pkg.sv | 27 ++
 rtl/stc0_bf_seq_cnt.sv | 27 ++
 rtl/stc0_bf_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_stc0_bf_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stc0_bf_seq_pkg.sv
// Shared definitions for the stc0 butterfly-chain configuration sequencer:
// FSM state encoding, control-word field positions and twiddle table depth.
package stc0_bf_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_LOAD = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_CFG_RUN  = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_t;

  // Butterfly control word fields (RB_BFCTRL_* register layout)
  localparam int unsigned RB_BFCTRL_BFBYPASS = 0;
  localparam int unsigned RB_BFCTRL_TWWR     = 1;
  localparam int unsigned RB_BFCTRL_SCALE_LO = 2;
  localparam int unsigned RB_BFCTRL_SCALE_W  = 2;

  // Twiddle table depth of stage s in a 2^n_log2-point chain
  function automatic int unsigned tw_depth(input int unsigned n_log2, input int unsigned s);
    return 32'd1 << (n_log2 - s - 32'd1);
  endfunction

endpackage

// File: rtl/stc0_bf_seq_cnt.sv
// Loadable down-counter with zero flag; times SETTLE, LOAD and DRAIN.
module stc0_bf_seq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/stc0_bf_seq.sv
// Configuration sequencer for the stc0 FFT butterfly chain: loads each
// multiplier stage's twiddle SRAM through the chained data path, then writes
// every stage's run-mode control word with its scale field.
// Optional abort path is compiled in with STC0_BFSEQ_ABORT_EN.
module stc0_bf_seq
  import stc0_bf_seq_pkg::*;
#(
  parameter int unsigned NUM_POINTS_LOG2 = 10,
  parameter int unsigned DATA_WIDTH      = 17,
  parameter int unsigned TW_WIDTH        = 16,
  parameter int unsigned CTRLWRD_SZ      = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
`ifdef STC0_BFSEQ_ABORT_EN
  input  logic                         Abort,
  output logic                         Aborted,
`endif
  input  logic [2*NUM_POINTS_LOG2-1:0] ScaleSched,
  output logic                         Busy,
  output logic                         Done,
  input  logic [2*TW_WIDTH-1:0]        TwData,
  input  logic                         TwValid,
  output logic                         TwReady,
  output logic [3:0]                   CtrlAddr,
  output logic [CTRLWRD_SZ-1:0]        CtrlWord,
  output logic                         CtrlValid,
  output logic [DATA_WIDTH-1:0]        Ar,
  output logic [DATA_WIDTH-1:0]        Ai,
  output logic [DATA_WIDTH-1:0]        Br,
  output logic [DATA_WIDTH-1:0]        Bi,
  output logic                         IngressValid
);

  localparam int unsigned N     = NUM_POINTS_LOG2;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = NUM_POINTS_LOG2 + 1;

  localparam logic [CTRLWRD_SZ-1:0] BYP_WORD  = CTRLWRD_SZ'(1) << RB_BFCTRL_BFBYPASS;
  localparam logic [CTRLWRD_SZ-1:0] TWWR_WORD = CTRLWRD_SZ'(1) << RB_BFCTRL_TWWR;

  seq_state_t           state;
  logic [SW-1:0]        stage;
  logic [SW-1:0]        idx;
  logic [2*N-1:0]       sched_q;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_val;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_zero;

  logic                 acc;
  logic                 last_acc;
  logic                 more_stages;
  logic                 abort_hit;
  logic                 aborted_q;
  logic [TW_WIDTH-1:0]  tw_r;
  logic [TW_WIDTH-1:0]  tw_i;

  assign tw_r        = TwData[2*TW_WIDTH-1:TW_WIDTH];
  assign tw_i        = TwData[TW_WIDTH-1:0];
  assign acc         = TwValid && TwReady;
  assign last_acc    = acc && (cnt == CNT_W'(1));
  assign more_stages = (32'(stage) + 32'd3) < N;

  // Sign-extend a twiddle component onto a data lane
  function automatic logic [DATA_WIDTH-1:0] sext(input logic [TW_WIDTH-1:0] v);
    return DATA_WIDTH'($signed(v));
  endfunction

  // Run-mode word for stage a; an aborted sequence bypasses every stage instead
  function automatic logic [CTRLWRD_SZ-1:0] run_word(input logic [2*N-1:0] sched,
                                                     input logic           byp,
                                                     input logic [SW-1:0]  a);
    logic [CTRLWRD_SZ-1:0] w;
    w = '0;
    if (byp) begin
      w = BYP_WORD;
    end else begin
      w[RB_BFCTRL_SCALE_LO +: RB_BFCTRL_SCALE_W] = sched[2*a +: 2];
    end
    return w;
  endfunction

  stc0_bf_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero_c   (cnt_zero)
  );

  // Counter schedule: SETTLE s+2 cycles, LOAD D(s) accepts, DRAIN 2s+2 cycles
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_CFG_LOAD: begin
        if (idx == stage) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(stage) + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(tw_depth(N, 32'(stage)));
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        if (last_acc) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'({stage, 1'b1});
        end else if (acc) begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
      end
    endcase
  end

`ifdef STC0_BFSEQ_ABORT_EN
  assign abort_hit = Abort && (state != ST_IDLE) && !aborted_q;
  assign Aborted   = aborted_q;

  // Abort flag: set on the first abort of a sequence, cleared by the next Start
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      aborted_q <= 1'b0;
    end else if ((state == ST_IDLE) && Start) begin
      aborted_q <= 1'b0;
    end else if (abort_hit) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
  assign aborted_q = 1'b0;
`endif

  // Sequencer FSM; each output is set on the edge entering the cycle it applies to
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= ST_IDLE;
      stage        <= '0;
      idx          <= '0;
      sched_q      <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      TwReady      <= 1'b0;
      CtrlValid    <= 1'b0;
      CtrlAddr     <= '0;
      CtrlWord     <= '0;
      Ar           <= '0;
      Ai           <= '0;
      Br           <= '0;
      Bi           <= '0;
      IngressValid <= 1'b0;
    end else begin
      Done         <= 1'b0;
      IngressValid <= acc;
      if (acc) begin
        Ar <= sext(tw_r);
        Br <= sext(tw_r);
        Ai <= sext(tw_i);
        Bi <= sext(tw_i);
      end

      if (abort_hit) begin
        state     <= ST_CFG_RUN;
        stage     <= '0;
        idx       <= '0;
        TwReady   <= 1'b0;
        CtrlValid <= 1'b1;
        CtrlAddr  <= '0;
        CtrlWord  <= BYP_WORD;
      end else begin
        case (state)
          ST_IDLE: begin
            if (Start) begin
              state     <= ST_CFG_LOAD;
              sched_q   <= ScaleSched;
              stage     <= '0;
              idx       <= '0;
              Busy      <= 1'b1;
              CtrlValid <= 1'b1;
              CtrlAddr  <= '0;
              CtrlWord  <= TWWR_WORD;
            end
          end

          ST_CFG_LOAD: begin
            if (idx == stage) begin
              state     <= ST_SETTLE;
              CtrlValid <= 1'b0;
              CtrlAddr  <= '0;
              CtrlWord  <= '0;
            end else begin
              idx      <= idx + SW'(1);
              CtrlAddr <= idx + SW'(1);
              CtrlWord <= ((idx + SW'(1)) == stage) ? TWWR_WORD : BYP_WORD;
            end
          end

          ST_SETTLE: begin
            if (cnt_zero) begin
              state <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            if (last_acc) begin
              state   <= ST_DRAIN;
              TwReady <= 1'b0;
            end else begin
              TwReady <= 1'b1;
            end
          end

          ST_DRAIN: begin
            if (cnt_zero) begin
              idx       <= '0;
              CtrlValid <= 1'b1;
              CtrlAddr  <= '0;
              if (more_stages) begin
                state    <= ST_CFG_LOAD;
                stage    <= stage + SW'(1);
                CtrlWord <= BYP_WORD;
              end else begin
                state    <= ST_CFG_RUN;
                stage    <= '0;
                CtrlWord <= run_word(sched_q, aborted_q, SW'(0));
              end
            end
          end

          ST_CFG_RUN: begin
            if (idx == SW'(N - 1)) begin
              state     <= ST_DONE;
              CtrlValid <= 1'b0;
              CtrlAddr  <= '0;
              CtrlWord  <= '0;
              Done      <= 1'b1;
            end else begin
              idx      <= idx + SW'(1);
              CtrlAddr <= idx + SW'(1);
              CtrlWord <= run_word(sched_q, aborted_q, idx + SW'(1));
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stc0_bf_seq.sv
// Self-checking bench for stc0_bf_seq at NUM_POINTS_LOG2=4.
// Build with STC0_BFSEQ_ABORT_EN to include the abort scenario.
module tb_stc0_bf_seq;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [7:0]  ScaleSched;
  logic        Busy;
  logic        Done;
  logic [31:0] TwData;
  logic        TwValid;
  logic        TwReady;
  logic [3:0]  CtrlAddr;
  logic [7:0]  CtrlWord;
  logic        CtrlValid;
  logic [16:0] Ar, Ai, Br, Bi;
  logic        IngressValid;
`ifdef STC0_BFSEQ_ABORT_EN
  logic        Abort;
  logic        Aborted;
`endif

  stc0_bf_seq #(
    .NUM_POINTS_LOG2 (4),
    .DATA_WIDTH      (17),
    .TW_WIDTH        (16),
    .CTRLWRD_SZ      (8)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Start        (Start),
`ifdef STC0_BFSEQ_ABORT_EN
    .Abort        (Abort),
    .Aborted      (Aborted),
`endif
    .ScaleSched   (ScaleSched),
    .Busy         (Busy),
    .Done         (Done),
    .TwData       (TwData),
    .TwValid      (TwValid),
    .TwReady      (TwReady),
    .CtrlAddr     (CtrlAddr),
    .CtrlWord     (CtrlWord),
    .CtrlValid    (CtrlValid),
    .Ar           (Ar),
    .Ai           (Ai),
    .Br           (Br),
    .Bi           (Bi),
    .IngressValid (IngressValid)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  logic [11:0] wr_q[$];
  logic [67:0] ing_q[$];
  logic [31:0] words[$];
  int          done_cnt, done_c, first_ctrl_c;
  logic        busy_c1, busy_cdone, busy_after;
  bit          timed_out, reset_hit;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] sx(input logic [15:0] v);
    return {v[15], v};
  endfunction

  // One Start-to-Done sequence; DUT outputs observed and inputs driven at each negedge
  task automatic run_seq(input logic [7:0] sched, input bit toggle, input int busy_start_at,
                         input int rst_at_word, input int abort_at, input bit neg_first);
    int          widx;
    logic [31:0] w;
    widx = 0;
    wr_q.delete(); ing_q.delete(); words.delete();
    done_cnt = 0; done_c = -1; first_ctrl_c = -1;
    busy_c1 = 1'bx; busy_cdone = 1'bx; busy_after = 1'bx;
    timed_out = 1'b1; reset_hit = 1'b0;
    for (int k = 0; k < 14; k++) begin
      w = $urandom;
      if (k == 0 && neg_first) w = 32'h8000_7FFF;
      words.push_back(w);
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      if (CtrlValid) begin
        wr_q.push_back({CtrlAddr, CtrlWord});
        if (first_ctrl_c < 0) first_ctrl_c = c;
      end
      if (IngressValid) ing_q.push_back({Ar, Ai, Br, Bi});
      if (c == 1) busy_c1 = Busy;
      if (Done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c     = c;
          busy_cdone = Busy;
        end
      end
      if (done_c >= 0 && c == done_c + 1) busy_after = Busy;
      if (done_c >= 0 && c == done_c + 4) begin
        timed_out = 1'b0;
        break;
      end
      Start      = (c == 0) || (c == busy_start_at);
      ScaleSched = (c == 0) ? sched : ~sched;
`ifdef STC0_BFSEQ_ABORT_EN
      Abort      = (c == abort_at);
`endif
      TwValid    = toggle ? ((c % 2) == 0) : 1'b1;
      TwData     = words[widx];
      if (rst_at_word >= 0 && widx == rst_at_word) begin
        reset_hit = 1'b1;
        timed_out = 1'b0;
        Rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {Busy, Done, TwReady, CtrlValid, CtrlAddr, CtrlWord}, '0);
        chk("rst_mid_lanes", {Ar, Ai, Br, Bi, IngressValid}, '0);
        break;
      end
      if (TwValid && TwReady && widx < 13) widx++;
    end
    Start   = 1'b0;
    TwValid = 1'b0;
`ifdef STC0_BFSEQ_ABORT_EN
    Abort   = 1'b0;
`endif
    if (reset_hit) begin
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
    end
    if (abort_at < -1) $display("unused abort_at=%0d", abort_at);
  endtask

  // Expected control-write list from the sequencing rules
  task automatic check_ctrl(input string tag, input logic [7:0] sched, input bit aborted_run);
    logic [11:0] exp_q[$];
    logic [1:0]  sc;
    if (!aborted_run) begin
      for (int s = 0; s < N - 2; s++)
        for (int a = 0; a <= s; a++)
          exp_q.push_back({4'(a), (a == s) ? 8'h02 : 8'h01});
      for (int a = 0; a < N; a++) begin
        sc = sched[2*a +: 2];
        exp_q.push_back({4'(a), 4'h0, sc, 2'b00});
      end
    end else begin
      exp_q.push_back({4'd0, 8'h02});
      for (int a = 0; a < N; a++) exp_q.push_back({4'(a), 8'h01});
    end
    chk($sformatf("%s_wr_count", tag), wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  // Ingress lanes must replay the offered words in order, sign-extended
  task automatic check_ingress(input string tag, input int n_exp);
    logic [67:0] e;
    chk($sformatf("%s_ing_count", tag), ing_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < ing_q.size(); k++) begin
      e = {sx(words[k][31:16]), sx(words[k][15:0]), sx(words[k][31:16]), sx(words[k][15:0])};
      chk($sformatf("%s_ing%0d", tag, k), ing_q[k], e);
    end
  endtask

  logic [7:0]  sched_r;
  logic [67:0] first_ing;

  initial begin
    Rst = 1'b1; Start = 1'b0; ScaleSched = '0; TwData = '0; TwValid = 1'b0;
`ifdef STC0_BFSEQ_ABORT_EN
    Abort = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    chk("reset_ctrl", {Busy, Done, TwReady, CtrlValid, CtrlAddr, CtrlWord}, '0);
    chk("reset_lanes", {Ar, Ai, Br, Bi, IngressValid}, '0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("idle_ctrl", {Busy, Done, TwReady, CtrlValid, CtrlAddr, CtrlWord}, '0);
    chk("idle_ingress", IngressValid, 1'b0);

    // Main sequence, TwValid held high
    run_seq(8'hE4, 1'b0, -1, -1, -1, 1'b0);
    chk("e4_done_seen", timed_out, 1'b0);
    check_ctrl("e4", 8'hE4, 1'b0);
    check_ingress("e4", 12);
    chk("e4_done_cycle", done_c, 33);
    chk("e4_done_count", done_cnt, 1);
    chk("e4_first_ctrl", first_ctrl_c, 1);
    chk("e4_busy_c1", busy_c1, 1'b1);
    chk("e4_busy_done", busy_cdone, 1'b1);
    chk("e4_busy_after", busy_after, 1'b0);

    // TwValid toggling during LOAD
    sched_r = 8'($urandom);
    run_seq(sched_r, 1'b1, -1, -1, -1, 1'b0);
    chk("tog_done_seen", timed_out, 1'b0);
    check_ctrl("tog", sched_r, 1'b0);
    check_ingress("tog", 12);
    chk("tog_done_count", done_cnt, 1);

    // Start pulsed while Busy
    sched_r = 8'($urandom);
    run_seq(sched_r, 1'b0, 10, -1, -1, 1'b0);
    chk("busy_done_seen", timed_out, 1'b0);
    check_ctrl("busy", sched_r, 1'b0);
    chk("busy_done_count", done_cnt, 1);
    chk("busy_done_cycle", done_c, 33);

    // Reset mid-LOAD, then a clean restart
    run_seq(8'hE4, 1'b0, -1, 5, -1, 1'b0);
    chk("rst_hit", reset_hit, 1'b1);
    chk("rst_idle", {Busy, TwReady, CtrlValid, IngressValid}, '0);
    sched_r = 8'($urandom);
    run_seq(sched_r, 1'b0, -1, -1, -1, 1'b0);
    chk("restart_done_seen", timed_out, 1'b0);
    check_ctrl("restart", sched_r, 1'b0);
    check_ingress("restart", 12);
    chk("restart_done_cycle", done_c, 33);

    // Negative twiddle sign extension
    run_seq(8'h1B, 1'b0, -1, -1, -1, 1'b1);
    chk("neg_done_seen", timed_out, 1'b0);
    check_ingress("neg", 12);
    first_ing = (ing_q.size() > 0) ? ing_q[0] : '0;
    chk("neg_br", first_ing[33:17], 17'h18000);
    chk("neg_ar", first_ing[67:51], 17'h18000);
    chk("neg_bi", first_ing[16:0], 17'h07FFF);

`ifdef STC0_BFSEQ_ABORT_EN
    // Abort during SETTLE of stage 0
    run_seq(8'hE4, 1'b0, -1, -1, 2, 1'b0);
    chk("abort_done_seen", timed_out, 1'b0);
    check_ctrl("abort", 8'hE4, 1'b1);
    chk("abort_done_count", done_cnt, 1);
    chk("abort_ing_count", ing_q.size(), 0);
    chk("abort_flag", Aborted, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
